race_light_sequencer: RTL and testbench

- Parametrised multi-lane race start-light controller.
- Runs a red → yellow → green countdown with per-phase programmable durations.
- Detects per-lane false starts (launch before green) and captures per-lane reaction time in clock cycles during green.
- Sits between the start/abort control logic and the lane launch sensors; drives the light tree and reports results to the scoring logic.

---
 rtl/race_light_sequencer.sv | 158 +++++++++++++++
 tb/tb_race_light_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/race_light_sequencer.sv
// race_light_sequencer
//   Multi-lane race start-light controller. Runs a red -> yellow -> green
//   countdown with per-phase durations, flags lanes that launch before green,
//   and records each lane's first launch during green as the green-cycle
//   index (reaction time in clock cycles).
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   start        begins a sequence (sampled only in IDLE, ignored with abort)
//   abort        cancels a running sequence
//   lane_go      per-lane launch sensors, bit i = lane i
//   red/yellow/green  light tree, exactly one high at any time
//   busy         high while RED, YELLOW or GREEN
//   done         one-cycle pulse after a normal GREEN exit
//   aborted      one-cycle pulse after an abort
//   false_start  sticky per-lane false-start flags
//   react_valid  sticky per-lane reaction-captured flags
//   react_time   lane i at [i*CNT_W +: CNT_W], green-cycle index of first launch
module race_light_sequencer #(
  parameter int LANES         = 4,
  parameter int RED_CYCLES    = 3,
  parameter int YELLOW_CYCLES = 3,
  parameter int GREEN_CYCLES  = 3,
  parameter int CNT_W         = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [LANES-1:0]       lane_go,
  output logic                   red,
  output logic                   yellow,
  output logic                   green,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic [LANES-1:0]       false_start,
  output logic [LANES-1:0]       react_valid,
  output logic [LANES*CNT_W-1:0] react_time
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RED    = 2'd1,
    S_YELLOW = 2'd2,
    S_GREEN  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_CYCLES - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             start_acc;
  logic             done_nxt;
  logic             aborted_nxt;

  // State register and phase counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      state   <= state_nxt;
      done    <= done_nxt;
      aborted <= aborted_nxt;
      // Counter restarts at 0 on every phase entry and idles at 0.
      if (state_nxt != state || state == S_IDLE) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Next-state decode and Moore lamp outputs.
  always_comb begin
    state_nxt   = state;
    start_acc   = 1'b0;
    done_nxt    = 1'b0;
    aborted_nxt = 1'b0;
    red         = 1'b0;
    yellow      = 1'b0;
    green       = 1'b0;
    busy        = 1'b0;
    case (state)
      S_IDLE: begin
        red = 1'b1;
        // start together with abort is refused, sequence never begins.
        if (start && !abort) begin
          state_nxt = S_RED;
          start_acc = 1'b1;
        end
      end
      S_RED: begin
        red  = 1'b1;
        busy = 1'b1;
        if (abort) begin
          state_nxt   = S_IDLE;
          aborted_nxt = 1'b1;
        end else if (cnt == RED_LAST) begin
          state_nxt = S_YELLOW;
        end
      end
      S_YELLOW: begin
        yellow = 1'b1;
        busy   = 1'b1;
        if (abort) begin
          state_nxt   = S_IDLE;
          aborted_nxt = 1'b1;
        end else if (cnt == YELLOW_LAST) begin
          state_nxt = S_GREEN;
        end
      end
      S_GREEN: begin
        green = 1'b1;
        busy  = 1'b1;
        // abort on the final green cycle still counts as a cancellation.
        if (abort) begin
          state_nxt   = S_IDLE;
          aborted_nxt = 1'b1;
        end else if (cnt == GREEN_LAST) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        red       = 1'b1;
      end
    endcase
  end

  // Per-lane result capture; results survive abort and are only cleared by
  // reset or by the next accepted start.
  always_ff @(posedge clk) begin
    if (reset || start_acc) begin
      false_start <= '0;
      react_valid <= '0;
      react_time  <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if ((state == S_RED || state == S_YELLOW) && lane_go[i]) begin
          false_start[i] <= 1'b1;
        end
        if (state == S_GREEN && lane_go[i] && !react_valid[i] && !false_start[i]) begin
          react_valid[i]                  <= 1'b1;
          react_time[i*CNT_W +: CNT_W] <= cnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_race_light_sequencer.sv
module tb_race_light_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  // Default-parameter instance.
  logic        start = 1'b0, abort = 1'b0;
  logic [3:0]  lane_go = '0;
  logic        red, yellow, green, busy, done, aborted;
  logic [3:0]  false_start, react_valid;
  logic [31:0] react_time;

  // Short-phase, single-lane instance.
  logic        start_s = 1'b0, abort_s = 1'b0;
  logic [0:0]  lane_go_s = '0;
  logic        red_s, yellow_s, green_s, busy_s, done_s, aborted_s;
  logic [0:0]  false_start_s, react_valid_s;
  logic [7:0]  react_time_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  race_light_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .lane_go(lane_go),
    .red(red), .yellow(yellow), .green(green), .busy(busy), .done(done),
    .aborted(aborted), .false_start(false_start), .react_valid(react_valid),
    .react_time(react_time)
  );

  race_light_sequencer #(
    .LANES(1), .RED_CYCLES(1), .YELLOW_CYCLES(2), .GREEN_CYCLES(5), .CNT_W(8)
  ) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .abort(abort_s), .lane_go(lane_go_s),
    .red(red_s), .yellow(yellow_s), .green(green_s), .busy(busy_s), .done(done_s),
    .aborted(aborted_s), .false_start(false_start_s), .react_valid(react_valid_s),
    .react_time(react_time_s)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_lamps(input string tag, input logic r, input logic y,
                             input logic g, input logic b);
    check({tag, " red"}, red, r);
    check({tag, " yellow"}, yellow, y);
    check({tag, " green"}, green, g);
    check({tag, " busy"}, busy, b);
  endtask

  initial begin
    // Reset for two cycles.
    tick();
    tick();
    check_lamps("rst", 1, 0, 0, 0);
    check("rst done", done, 0);
    check("rst aborted", aborted, 0);
    check("rst fs", false_start, 4'h0);
    check("rst rv", react_valid, 4'h0);
    check("rst rt", react_time, 32'h0);
    reset = 1'b0;

    // Sequence A: full run with captures and a lane-1 false start.
    for (int c = 0; c <= 12; c++) begin
      logic [3:0]  e_fs, e_rv;
      logic [31:0] e_rt;
      if (c >= 1) begin
        check_lamps($sformatf("A c%0d", c), !(c >= 4 && c <= 9), (c >= 4 && c <= 6),
                    (c >= 7 && c <= 9), (c >= 1 && c <= 9));
        check($sformatf("A c%0d done", c), done, (c == 10));
        check($sformatf("A c%0d aborted", c), aborted, 0);
        e_fs = (c >= 6) ? 4'b0010 : 4'b0000;
        e_rv = ((c >= 8) ? 4'b0001 : 4'b0000) | ((c >= 9) ? 4'b0100 : 4'b0000);
        e_rt = (c >= 9) ? 32'h0001_0000 : 32'h0;
        check($sformatf("A c%0d fs", c), false_start, e_fs);
        check($sformatf("A c%0d rv", c), react_valid, e_rv);
        check($sformatf("A c%0d rt", c), react_time, e_rt);
      end
      start      = (c == 0);
      lane_go    = '0;
      lane_go[0] = (c >= 7 && c <= 9);
      lane_go[1] = (c == 5 || c == 8);
      lane_go[2] = (c == 8);
      tick();
    end

    // Sequence B: new start clears results, lane-3 false start, abort in yellow.
    for (int c = 0; c <= 12; c++) begin
      if (c == 1) begin
        check("B clr fs", false_start, 4'h0);
        check("B clr rv", react_valid, 4'h0);
        check("B clr rt", react_time, 32'h0);
      end
      if (c >= 1) begin
        check_lamps($sformatf("B c%0d", c), !(c >= 4 && c <= 5), (c >= 4 && c <= 5),
                    0, (c >= 1 && c <= 5));
        check($sformatf("B c%0d aborted", c), aborted, (c == 6));
        check($sformatf("B c%0d done", c), done, 0);
        check($sformatf("B c%0d fs", c), false_start, (c >= 3) ? 4'b1000 : 4'b0000);
      end
      start      = (c == 0 || c == 5);
      abort      = (c == 5);
      lane_go    = '0;
      lane_go[3] = (c == 2);
      tick();
    end

    // start with abort in IDLE is refused; results stay untouched.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_lamps("SA", 1, 0, 0, 0);
    check("SA fs kept", false_start, 4'b1000);
    tick();
    check("SA busy later", busy, 0);

    // Sequence C: reset during green clears everything, no pulses.
    for (int c = 0; c <= 10; c++) begin
      if (c == 8) begin
        check("C pre rv", react_valid, 4'b0001);
        check("C pre fs", false_start, 4'b1000);
      end
      if (c >= 9) begin
        check_lamps($sformatf("C c%0d", c), 1, 0, 0, 0);
        check($sformatf("C c%0d done", c), done, 0);
        check($sformatf("C c%0d aborted", c), aborted, 0);
        check($sformatf("C c%0d fs", c), false_start, 4'h0);
        check($sformatf("C c%0d rv", c), react_valid, 4'h0);
        check($sformatf("C c%0d rt", c), react_time, 32'h0);
      end
      start      = (c == 0);
      reset      = (c == 8);
      lane_go    = '0;
      lane_go[3] = (c == 4);
      lane_go[0] = (c == 7);
      tick();
    end
    reset = 1'b0;

    // Short-phase instance: red 1, yellow 2-3, green 4-8, done 9.
    for (int c = 0; c <= 10; c++) begin
      if (c >= 1) begin
        check($sformatf("S c%0d red", c), red_s, (c == 1 || c >= 9));
        check($sformatf("S c%0d yellow", c), yellow_s, (c >= 2 && c <= 3));
        check($sformatf("S c%0d green", c), green_s, (c >= 4 && c <= 8));
        check($sformatf("S c%0d busy", c), busy_s, (c >= 1 && c <= 8));
        check($sformatf("S c%0d done", c), done_s, (c == 9));
        check($sformatf("S c%0d rv", c), react_valid_s, (c >= 9));
        check($sformatf("S c%0d rt", c), react_time_s, (c >= 9) ? 8'd4 : 8'd0);
        check($sformatf("S c%0d fs", c), false_start_s, 1'b0);
      end
      start_s   = (c == 0);
      lane_go_s = (c == 8);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
